hsi2rgb: RTL and testbench
==========================

Name: hsi2rgb

Overview:
- Converts one HSI pixel per cycle back to 8-bit RGB. It is the inverse of the RGB-to-HSI stage on the style-transfer path.
- Sits after the HSI-domain style adjustment and before the RGB video output and display write.
- Fixed 4-stage pipeline with valid/ready flow control on both sides. The whole pipeline stalls globally when the output is held.

Parameters:
- LATENCY, 4, pipeline depth in cycles from accept to oValid. Documentation only; not overridable.

Ports:
- iCLK      input   1  clock; all state updates on the rising edge
- iRST_N    input   1  reset; synchronous, active-low
- iValid    input   1  upstream pixel valid
- oReady    output  1  upstream may present the next pixel
- iHue      input   9  hue in degrees, nominal 0..359
- iSaturation input 8  saturation 0..255
- iIntensity  input 8  intensity 0..255
- oValid    output  1  output pixel valid
- iReady    input   1  downstream accepts the output pixel
- oR, oG, oB output 8 each  RGB result

Behaviour:
- Reset: when iRST_N=0 at a clock edge, all stage-valid bits clear and oR/oG/oB become 0. oValid=0 from the next cycle. Reset mid-stream discards all in-flight pixels; no partial output is produced.
- Stall: advance = !oValid || iReady. oReady = advance, combinational. Every stage register loads only when advance=1; otherwise all stages hold data and valid.
- A pixel is accepted on a cycle with iValid && oReady. Bubbles propagate as valid=0.
- Latency: a pixel accepted at edge N appears with oValid=1 after edge N+4 when there is no stall. Each stall cycle adds one cycle. Output order equals input order, with no drops or duplicates.
- S1:
  - h = iHue; if iHue>=360 then h = iHue-360 (wrap).
  - sector = 0 for h<120, 1 for h<240, else 2. hp = h - 120*sector (7 bits, 0..119).
  - sum = 3*iIntensity (10 bits). Register S and I.
- S2: min = floor((255-S)*I/255), 8 bits. Exact integer division by the constant.
- S3:
  - d = sum - 3*min (10 bits; always >=0).
  - delta = floor(hp*d/120) (10 bits).
  - mid = min + delta; max = sum - 2*min - delta (10 bits each).
- S4 channel assignment:
  - sector 0: B=min, G=mid, R=max.
  - sector 1: R=min, B=mid, G=max.
  - sector 2: G=min, R=mid, B=max.
  - Each channel is saturated to 255 if >255.
- Grey case: S=0 gives min=I and d=0, so R=G=B=I regardless of hue.
- Black case: I=0 gives all channels 0.
- All intermediate widths must hold the maximum values without overflow:
  - (255-S)*I needs 16 bits.
  - hp*d needs 17 bits.

Optional Feature:
- Macro: HSI2RGB_PIX_COUNT_EN.
- Defined:
  - Adds output port oPixCount, 32 bits.
  - Counts output handshakes (oValid && iReady) and wraps at 2^32.
  - Cleared to 0 by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Grey: H=200, S=0, I=100, iReady=1 -> exactly 4 cycles later oValid=1, R=G=B=100.
- Primaries at I=85, S=255:
  - H=0 -> (255,0,0).
  - H=120 -> (0,255,0).
  - H=240 -> (0,0,255).
- Interpolation and clamp:
  - H=60, S=255, I=85 -> R=128, G=127, B=0.
  - H=0, S=255, I=255 -> R=255 (saturated from 765), G=0, B=0.
- Hue wrap: H=480, S=255, I=85 -> same as H=120 -> (0,255,0).
- Back-pressure:
  - Stream 6 distinct pixels, then hold iReady=0 for 5 cycles once oValid=1.
  - Required: oReady=0 and outputs stable during the hold; all 6 pixels emerge in order after release, with no loss or duplication.
- Reset mid-stream: pull iRST_N=0 for 1 cycle with 3 pixels in flight -> oValid=0 and RGB=0 the next cycle, and no stale pixel ever appears. With HSI2RGB_PIX_COUNT_EN defined, oPixCount=0 after reset.

Source files
------------

// File: rtl/hsi2rgb.sv
// HSI to 8-bit RGB converter: input capture plus four compute stages, globally stalled by output back-pressure.
// Optional output-handshake counter on port oPixCount when HSI2RGB_PIX_COUNT_EN is defined.
module hsi2rgb (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iValid,
   output logic       oReady,
   input  logic [8:0] iHue,
   input  logic [7:0] iSaturation,
   input  logic [7:0] iIntensity,
   output logic       oValid,
   input  logic       iReady,
   output logic [7:0] oR,
   output logic [7:0] oG,
   output logic [7:0] oB
`ifdef HSI2RGB_PIX_COUNT_EN
  ,output logic [31:0] oPixCount
`endif
);

   localparam int LATENCY = 4;

   function automatic logic [7:0] sat8(input logic [9:0] v);
      if (v > 10'd255) begin
         sat8 = 8'd255;
      end else begin
         sat8 = v[7:0];
      end
   endfunction

   logic       advance;

   logic       v0_q, v0_d;
   logic [8:0] hue0_q, hue0_d;
   logic [7:0] sat0_q, sat0_d;
   logic [7:0] int0_q, int0_d;

   logic       v1_q, v1_d;
   logic [1:0] sec1_q, sec1_d;
   logic [6:0] hp1_q, hp1_d;
   logic [9:0] sum1_q, sum1_d;
   logic [7:0] sat1_q, sat1_d;
   logic [7:0] int1_q, int1_d;

   logic       v2_q, v2_d;
   logic [1:0] sec2_q, sec2_d;
   logic [6:0] hp2_q, hp2_d;
   logic [9:0] sum2_q, sum2_d;
   logic [7:0] min2_q, min2_d;

   logic       v3_q, v3_d;
   logic [1:0] sec3_q, sec3_d;
   logic [9:0] min3_q, min3_d;
   logic [9:0] mid3_q, mid3_d;
   logic [9:0] max3_q, max3_d;

   logic       v4_q, v4_d;
   logic [7:0] r4_q, r4_d;
   logic [7:0] g4_q, g4_d;
   logic [7:0] b4_q, b4_d;

   logic [8:0]  h_w;
   logic [1:0]  sec_w;
   logic [6:0]  hp_w;
   logic [9:0]  sum_w;
   logic [7:0]  inv_s_w;
   logic [15:0] prod16_w;
   logic [7:0]  min_w;
   logic [9:0]  min10_w;
   logic [9:0]  two_min_w;
   logic [9:0]  d_w;
   logic [16:0] prod17_w;
   logic [9:0]  delta_w;

   // Every stage loads only while the output is empty or being consumed
   assign advance = !v4_q || iReady;
   assign oReady  = advance;
   assign oValid  = v4_q;
   assign oR      = r4_q;
   assign oG      = g4_q;
   assign oB      = b4_q;

   // Input capture
   always_comb begin
      v0_d   = v0_q;
      hue0_d = hue0_q;
      sat0_d = sat0_q;
      int0_d = int0_q;
      if (advance) begin
         v0_d   = iValid;
         hue0_d = iHue;
         sat0_d = iSaturation;
         int0_d = iIntensity;
      end else begin
         v0_d   = v0_q;
      end
   end

   // S1: hue wrap, sector split, 3*I
   always_comb begin
      h_w   = hue0_q;
      sec_w = 2'd0;
      hp_w  = 7'd0;
      if (hue0_q >= 9'd360) begin
         h_w = hue0_q - 9'd360;
      end else begin
         h_w = hue0_q;
      end
      if (h_w < 9'd120) begin
         sec_w = 2'd0;
         hp_w  = 7'(h_w);
      end else if (h_w < 9'd240) begin
         sec_w = 2'd1;
         hp_w  = 7'(h_w - 9'd120);
      end else begin
         sec_w = 2'd2;
         hp_w  = 7'(h_w - 9'd240);
      end
      sum_w  = {2'b00, int0_q} + {1'b0, int0_q, 1'b0};
      v1_d   = v1_q;
      sec1_d = sec1_q;
      hp1_d  = hp1_q;
      sum1_d = sum1_q;
      sat1_d = sat1_q;
      int1_d = int1_q;
      if (advance) begin
         v1_d   = v0_q;
         sec1_d = sec_w;
         hp1_d  = hp_w;
         sum1_d = sum_w;
         sat1_d = sat0_q;
         int1_d = int0_q;
      end else begin
         v1_d   = v1_q;
      end
   end

   // S2: min = floor((255-S)*I/255)
   always_comb begin
      inv_s_w  = 8'd255 - sat1_q;
      prod16_w = {8'd0, inv_s_w} * {8'd0, int1_q};
      min_w    = 8'(prod16_w / 16'd255);
      v2_d     = v2_q;
      sec2_d   = sec2_q;
      hp2_d    = hp2_q;
      sum2_d   = sum2_q;
      min2_d   = min2_q;
      if (advance) begin
         v2_d   = v1_q;
         sec2_d = sec1_q;
         hp2_d  = hp1_q;
         sum2_d = sum1_q;
         min2_d = min_w;
      end else begin
         v2_d   = v2_q;
      end
   end

   // S3: interpolate mid/max from the hue offset inside the sector
   always_comb begin
      min10_w   = {2'b00, min2_q};
      two_min_w = {1'b0, min2_q, 1'b0};
      d_w       = sum2_q - (min10_w + two_min_w);
      prod17_w  = {10'd0, hp2_q} * {7'd0, d_w};
      delta_w   = 10'(prod17_w / 17'd120);
      v3_d      = v3_q;
      sec3_d    = sec3_q;
      min3_d    = min3_q;
      mid3_d    = mid3_q;
      max3_d    = max3_q;
      if (advance) begin
         v3_d   = v2_q;
         sec3_d = sec2_q;
         min3_d = min10_w;
         mid3_d = min10_w + delta_w;
         max3_d = sum2_q - two_min_w - delta_w;
      end else begin
         v3_d   = v3_q;
      end
   end

   // S4: route min/mid/max to channels and saturate
   always_comb begin
      v4_d = v4_q;
      r4_d = r4_q;
      g4_d = g4_q;
      b4_d = b4_q;
      if (advance) begin
         v4_d = v3_q;
         case (sec3_q)
            2'd0: begin
               r4_d = sat8(max3_q);
               g4_d = sat8(mid3_q);
               b4_d = sat8(min3_q);
            end
            2'd1: begin
               r4_d = sat8(min3_q);
               g4_d = sat8(max3_q);
               b4_d = sat8(mid3_q);
            end
            2'd2: begin
               r4_d = sat8(mid3_q);
               g4_d = sat8(min3_q);
               b4_d = sat8(max3_q);
            end
            default: begin
               r4_d = 8'd0;
               g4_d = 8'd0;
               b4_d = 8'd0;
            end
         endcase
      end else begin
         v4_d = v4_q;
      end
   end

   // Pipeline state registers
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         v0_q <= 1'b0; hue0_q <= 9'd0; sat0_q <= 8'd0; int0_q <= 8'd0;
         v1_q <= 1'b0; sec1_q <= 2'd0; hp1_q <= 7'd0; sum1_q <= 10'd0;
         sat1_q <= 8'd0; int1_q <= 8'd0;
         v2_q <= 1'b0; sec2_q <= 2'd0; hp2_q <= 7'd0; sum2_q <= 10'd0; min2_q <= 8'd0;
         v3_q <= 1'b0; sec3_q <= 2'd0; min3_q <= 10'd0; mid3_q <= 10'd0; max3_q <= 10'd0;
         v4_q <= 1'b0; r4_q <= 8'd0; g4_q <= 8'd0; b4_q <= 8'd0;
      end else begin
         v0_q <= v0_d; hue0_q <= hue0_d; sat0_q <= sat0_d; int0_q <= int0_d;
         v1_q <= v1_d; sec1_q <= sec1_d; hp1_q <= hp1_d; sum1_q <= sum1_d;
         sat1_q <= sat1_d; int1_q <= int1_d;
         v2_q <= v2_d; sec2_q <= sec2_d; hp2_q <= hp2_d; sum2_q <= sum2_d; min2_q <= min2_d;
         v3_q <= v3_d; sec3_q <= sec3_d; min3_q <= min3_d; mid3_q <= mid3_d; max3_q <= max3_d;
         v4_q <= v4_d; r4_q <= r4_d; g4_q <= g4_d; b4_q <= b4_d;
      end
   end

`ifdef HSI2RGB_PIX_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Output handshake count, wraps naturally at 2^32
   always_comb begin
      if (v4_q && iReady) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign oPixCount = cnt_q;
`endif

endmodule

// File: tb/tb_hsi2rgb.sv
// Scoreboard bench for hsi2rgb: expectations queued on accept, compared on output handshake.
module tb_hsi2rgb;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       iValid = 1'b0;
   logic       oReady;
   logic [8:0] iHue = 9'd0;
   logic [7:0] iSaturation = 8'd0;
   logic [7:0] iIntensity = 8'd0;
   logic       oValid;
   logic       iReady = 1'b1;
   logic [7:0] oR, oG, oB;
`ifdef HSI2RGB_PIX_COUNT_EN
   logic [31:0] oPixCount;
`endif

   int checks = 0;
   int errors = 0;
   int n_out = 0;
   logic [23:0] exp_rgb = 24'd0;
   logic [23:0] mon_e;
   logic [23:0] exp_q[$];

   hsi2rgb dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid), .oReady(oReady),
      .iHue(iHue), .iSaturation(iSaturation), .iIntensity(iIntensity),
      .oValid(oValid), .iReady(iReady), .oR(oR), .oG(oG), .oB(oB)
`ifdef HSI2RGB_PIX_COUNT_EN
     ,.oPixCount(oPixCount)
`endif
   );

   always #5 iCLK = ~iCLK;

   function automatic logic [23:0] model(input int h_in, input int s, input int i);
      int h, sec, hp, sum, mn, d, dl, mid, mx, r, g, b;
      h = (h_in >= 360) ? h_in - 360 : h_in;
      sec = (h < 120) ? 0 : (h < 240) ? 1 : 2;
      hp = h - 120 * sec;
      sum = 3 * i;
      mn = ((255 - s) * i) / 255;
      d = sum - 3 * mn;
      dl = (hp * d) / 120;
      mid = mn + dl;
      mx = sum - 2 * mn - dl;
      if (sec == 0) begin r = mx; g = mid; b = mn; end
      else if (sec == 1) begin r = mn; g = mx; b = mid; end
      else begin r = mid; g = mn; b = mx; end
      if (r > 255) r = 255;
      if (g > 255) g = 255;
      if (b > 255) b = 255;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   // Scoreboard: push on accept, pop and compare on output handshake
   always @(negedge iCLK) begin
      if (!iRST_N) begin
         exp_q.delete();
         n_out = 0;
      end else begin
         if (oValid && iReady) begin
            checks++;
            n_out++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stale_output got %h want none", {oR, oG, oB});
            end else begin
               mon_e = exp_q.pop_front();
               if ({oR, oG, oB} !== mon_e) begin
                  errors++;
                  $display("FAIL pixel got %h want %h", {oR, oG, oB}, mon_e);
               end
            end
         end
         if (iValid && oReady) exp_q.push_back(exp_rgb);
      end
   end

   task automatic drive_pix(input logic [8:0] h, input logic [7:0] s, input logic [7:0] i,
                            input logic [23:0] e);
      bit acc = 1'b0;
      int n = 0;
      iHue = h; iSaturation = s; iIntensity = i; exp_rgb = e; iValid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge iCLK);
         acc = oReady;
         @(posedge iCLK); #1;
         n++;
      end
      iValid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL accept_timeout got oReady=0 want 1");
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || oValid) && n < 100) begin
         @(posedge iCLK); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || oValid) begin
         errors++;
         $display("FAIL drain got pending=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      iRST_N = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", oValid); end
      checks++;
      if ({oR, oG, oB} !== 24'd0) begin errors++; $display("FAIL reset_rgb got %h want 0", {oR, oG, oB}); end
      iRST_N = 1'b1;
      #1;
      checks++;
      if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", oReady); end
`ifdef HSI2RGB_PIX_COUNT_EN
      checks++;
      if (oPixCount !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", oPixCount); end
`endif
   endtask

   task automatic test_grey_latency();
      iReady = 1'b1;
      drive_pix(9'd200, 8'd0, 8'd100, {8'd100, 8'd100, 8'd100});
      for (int k = 1; k <= 4; k++) begin
         @(posedge iCLK); #1;
         checks++;
         if (oValid !== (k == 4)) begin
            errors++;
            $display("FAIL latency_cycle%0d got %b want %b", k, oValid, (k == 4));
         end
      end
      checks++;
      if ({oR, oG, oB} !== {8'd100, 8'd100, 8'd100}) begin
         errors++; $display("FAIL grey got %h want 646464", {oR, oG, oB});
      end
      wait_idle();
   endtask

   task automatic test_primaries();
      drive_pix(9'd0,   8'd255, 8'd85,  {8'd255, 8'd0,   8'd0});
      drive_pix(9'd120, 8'd255, 8'd85,  {8'd0,   8'd255, 8'd0});
      drive_pix(9'd240, 8'd255, 8'd85,  {8'd0,   8'd0,   8'd255});
      drive_pix(9'd60,  8'd255, 8'd85,  {8'd128, 8'd127, 8'd0});
      drive_pix(9'd0,   8'd255, 8'd255, {8'd255, 8'd0,   8'd0});
      drive_pix(9'd480, 8'd255, 8'd85,  {8'd0,   8'd255, 8'd0});
      drive_pix(9'd300, 8'd77,  8'd0,   {8'd0,   8'd0,   8'd0});
      drive_pix(9'd511, 8'd200, 8'd140, model(511, 200, 140));
      wait_idle();
   endtask

   task automatic test_back_pressure();
      logic [23:0] held;
      int n = 0;
      int h, s, i;
      iReady = 1'b1;
      for (int p = 0; p < 6; p++) begin
         h = $urandom_range(0, 511);
         s = $urandom_range(0, 255);
         i = 20 + 30 * p;
         drive_pix(h[8:0], s[7:0], i[7:0], model(h, s, i));
      end
      while (!oValid && n < 20) begin
         @(posedge iCLK); #1;
         n++;
      end
      iReady = 1'b0;
      held = {oR, oG, oB};
      for (int c = 0; c < 5; c++) begin
         @(negedge iCLK);
         checks++;
         if (oReady !== 1'b0 || oValid !== 1'b1) begin
            errors++; $display("FAIL hold_flags got ready=%b valid=%b want 0 1", oReady, oValid);
         end
         checks++;
         if ({oR, oG, oB} !== held) begin
            errors++; $display("FAIL hold_stable got %h want %h", {oR, oG, oB}, held);
         end
      end
      @(posedge iCLK); #1;
      iReady = 1'b1;
      #1;
      checks++;
      if (oReady !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", oReady); end
      wait_idle();
`ifdef HSI2RGB_PIX_COUNT_EN
      checks++;
      if (oPixCount !== n_out) begin errors++; $display("FAIL count got %0d want %0d", oPixCount, n_out); end
`endif
   endtask

   task automatic test_reset_midstream();
      iReady = 1'b1;
      drive_pix(9'd10,  8'd255, 8'd85, model(10, 255, 85));
      drive_pix(9'd130, 8'd128, 8'd90, model(130, 128, 90));
      drive_pix(9'd250, 8'd60,  8'd200, model(250, 60, 200));
      iRST_N = 1'b0;
      @(posedge iCLK); #1;
      iRST_N = 1'b1;
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", oValid); end
      checks++;
      if ({oR, oG, oB} !== 24'd0) begin errors++; $display("FAIL midreset_rgb got %h want 0", {oR, oG, oB}); end
`ifdef HSI2RGB_PIX_COUNT_EN
      checks++;
      if (oPixCount !== 32'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", oPixCount); end
`endif
      for (int c = 0; c < 10; c++) begin
         @(posedge iCLK); #1;
         checks++;
         if (oValid !== 1'b0) begin errors++; $display("FAIL stale_after_reset got %b want 0", oValid); end
      end
      drive_pix(9'd359, 8'd255, 8'd85, model(359, 255, 85));
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_grey_latency();
      test_primaries();
      test_back_pressure();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
